ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 18 +
 rtl/ram_loader.sv | 136 +++++++++++++
 tb/tb_ram_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared defaults and FSM encoding for ram_loader.
// The VERIFY state exists only when RAM_LOADER_VERIFY_EN is defined.
package ram_loader_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
`ifdef RAM_LOADER_VERIFY_EN
    ST_VERIFY = 3'd4,
`endif
    ST_DONE   = 3'd3
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Streams words from a valid/ready source into a RAM16K-style RAM, one word per two cycles.
// Optional read-back check of every word when RAM_LOADER_VERIFY_EN is defined.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  state_t state_reg, state_next;

  logic [ADDR_W:0] length_reg;
  logic [ADDR_W:0] count_inc;
  logic            last_word;
  logic            accept_start;
  logic            advance;

  assign count_inc    = word_count + 1'b1;
  assign last_word    = (count_inc == length_reg);
  assign accept_start = (state_reg == ST_IDLE) && start;

`ifdef RAM_LOADER_VERIFY_EN
  assign advance = (state_reg == ST_VERIFY);
`else
  assign advance = (state_reg == ST_WRITE);
`endif

  // Outputs are pure state decodes so reset removes them without a clock edge.
  assign s_ready  = (state_reg == ST_ACCEPT);
  assign ram_load = (state_reg == ST_WRITE);
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (s_valid) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
`ifdef RAM_LOADER_VERIFY_EN
        state_next = ST_VERIFY;
`else
        state_next = last_word ? ST_DONE : ST_ACCEPT;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        state_next = last_word ? ST_DONE : ST_ACCEPT;
      end
`endif
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_in      <= '0;
      ram_address <= '0;
      length_reg  <= '0;
      word_count  <= '0;
    end else begin
      if (accept_start) begin
        ram_address <= base_addr;
        length_reg  <= length;
        word_count  <= '0;
      end
      if (s_ready && s_valid) begin
        ram_in <= s_data;
      end
      // Address is ADDR_W wide, so the top of the RAM wraps to zero naturally.
      if (advance) begin
        word_count  <= count_inc;
        ram_address <= ram_address + 1'b1;
      end
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (accept_start) begin
      err_reg <= 1'b0;
    end else if ((state_reg == ST_VERIFY) && (ram_out != ram_in)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_ram_out;
  assign unused_ram_out = ^ram_out;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: RAM model, write scoreboard and immediate-assertion checks.
// Define RAM_LOADER_VERIFY_EN for both bench and RTL to exercise the read-back check.
module tb_ram_loader;

  localparam int DW = 16;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_address;
  logic          ram_load;
  logic [DW-1:0] ram_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // RAM16K model with an optional stuck-at-zero read at address 2
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          force_zero = 1'b0;

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = (force_zero && ram_address == AW'(2)) ? '0 : mem[ram_address];

  // Observation side of the scoreboard
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  int load_cnt  = 0;
  int ready_cnt = 0;
  int done_cnt  = 0;
  int span_cnt  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_load) begin
        obs_q.push_back({ram_address, ram_in});
        load_cnt++;
      end
      if (s_ready) ready_cnt++;
      if (done) done_cnt++;
      if (busy && !done) span_cnt++;
    end
  end

  int test_cnt = 0;
  int fail_cnt = 0;
  int load_base, ready_base, done_base, span_base;
  logic [AW-1:0] exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] len);
    @(negedge clk);
    load_base  = load_cnt;
    ready_base = ready_cnt;
    done_base  = done_cnt;
    span_base  = span_cnt;
    exp_addr   = b;
    start      = 1'b1;
    base_addr  = b;
    length     = len;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Present one word; with gap set, hold s_valid low through one ACCEPT cycle first.
  task automatic send(input logic [DW-1:0] d, input logic gap);
    int n;
    n = 0;
    if (gap) begin
      s_valid = 1'b0;
      while (!s_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) check("send_timeout", 32'(n), 32'd0);
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    s_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_sb(input string tag);
    logic [AW+DW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) check({tag, "_missing"}, 32'd0, 32'(e));
      else check({tag, "_write"}, 32'(obs_q.pop_front()), 32'(e));
    end
    check({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; s_data = '0; s_valid = 1'b0;
    #3;
    check("rst_outputs", {busy, done, err, ram_load, s_ready}, 32'd0);
    check("rst_regs", {ram_address, word_count}, 32'd0);
    check("rst_ram_in", 32'(ram_in), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic three-word load with s_valid held
    do_start(AW'(1), 15'd3);
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b0);
    send(16'h1234, 1'b0);
    wait_idle();
    check_sb("basic");
    check("basic_mem", {mem[1], mem[2]}, {16'hAAAA, 16'h5555});
    check("basic_mem3", 32'(mem[3]), 32'h1234);
    check("basic_done", 32'(done_cnt - done_base), 32'd1);
    check("basic_count", 32'(word_count), 32'd3);
`ifdef RAM_LOADER_VERIFY_EN
    check("basic_span", 32'(span_cnt - span_base), 32'd9);
`else
    check("basic_span", 32'(span_cnt - span_base), 32'd6);
`endif
    check("basic_err", 32'(err), 32'd0);

    // Address wrap at the top of the RAM
    do_start(AW'(16'h3FFF), 15'd2);
    send(16'hBEEF, 1'b0);
    send(16'hCAFE, 1'b0);
    wait_idle();
    check_sb("wrap");
    check("wrap_mem", {mem[16'h3FFF], mem[0]}, {16'hBEEF, 16'hCAFE});

    // Zero-length load
    do_start(AW'(16'h0040), 15'd0);
    check("zero_done_next", 32'(done), 32'd1);
    wait_idle();
    check("zero_loads", 32'(load_cnt - load_base), 32'd0);
    check("zero_ready", 32'(ready_cnt - ready_base), 32'd0);
    check("zero_done_cnt", 32'(done_cnt - done_base), 32'd1);

    // Gapped stream
    do_start(AW'(16'h0080), 15'd4);
    send(16'h0101, 1'b1);
    send(16'h0202, 1'b1);
    send(16'h0303, 1'b1);
    send(16'h0404, 1'b1);
    wait_idle();
    check_sb("gap");
    check("gap_loads", 32'(load_cnt - load_base), 32'd4);
    check("gap_count", 32'(word_count), 32'd4);

    // Start while busy is ignored, then reset during the second WRITE
    do_start(AW'(16'h0100), 15'd4);
    send(16'h1001, 1'b0);
    start = 1'b1; base_addr = '0; length = 15'd1;
    @(negedge clk);
    start = 1'b0;
    send(16'h1002, 1'b0);
    check("abort_load_pre", {ram_load, ram_address}, {1'b1, 14'h0101});
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, ram_load, s_ready}, 32'd0);
    check("abort_regs", {ram_address, word_count}, 32'd0);
    if (exp_q.size() > 0) check("abort_first", 32'(obs_q.size() > 0 ? obs_q.pop_front() : '0), 32'(exp_q.pop_front()));
    exp_q.delete();
    check("abort_extra", 32'(obs_q.size()), 32'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);

    do_start(AW'(16'h0200), 15'd2);
    send(16'h2001, 1'b0);
    send(16'h2002, 1'b0);
    wait_idle();
    check_sb("after_abort");
    check("after_abort_done", 32'(done_cnt - done_base), 32'd1);

`ifdef RAM_LOADER_VERIFY_EN
    // Read-back mismatch at address 2
    force_zero = 1'b1;
    do_start(AW'(1), 15'd3);
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    wait_idle();
    check_sb("verify");
    check("verify_err", 32'(err), 32'd1);
    check("verify_done", {word_count, 1'b0} | 32'(done_cnt - done_base), 32'd7);
    force_zero = 1'b0;
    do_start(AW'(16'h0010), 15'd1);
    check("verify_err_clear", 32'(err), 32'd0);
    send(16'h4444, 1'b0);
    wait_idle();
    check_sb("verify_clean");
    check("verify_clean_err", 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
